// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the PC, issues in-order
// requests to a variable-latency instruction memory, tags each request with
// its address, and buffers returned words in a DEPTH-entry FIFO that decode
// drains through a valid/ready handshake. A redirect flushes the FIFO and
// marks every in-flight response as stale so it is dropped on return.
`timescale 1ns/1ps

module fetch_queue #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter int                  DEPTH    = 4,
  parameter int                  MAX_OUT  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                d_clk,
  input  logic                d_rst,
  input  logic                d_i_ce,
  input  logic                i_redirect,
  input  logic [PC_WIDTH-1:0] i_redirect_pc,
  output logic                o_imem_req,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic                i_imem_valid,
  input  logic [IWIDTH-1:0]   i_imem_instr,
  output logic                o_valid,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [IWIDTH-1:0]   o_instr,
  input  logic                i_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  localparam logic [OW-1:0] MAX_OUT_V = OW'(MAX_OUT);
  localparam logic [SW-1:0] DEPTH_V   = SW'(DEPTH);
  localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [OW-1:0]       outstanding;
  logic [OW-1:0]       discard;
  logic [OW-1:0]       outstanding_next;
  logic [CW-1:0]       count;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [TW-1:0]       tag_wr;
  logic [TW-1:0]       tag_rd;
  logic [SW-1:0]       credit_sum;
  logic                issue;
  logic                push;
  logic                pop;
  logic                head_valid;
  logic                redirect_low_unused;

  logic [PC_WIDTH-1:0] tag_mem    [MAX_OUT];
  logic [PC_WIDTH-1:0] fifo_pc    [DEPTH];
  logic [IWIDTH-1:0]   fifo_instr [DEPTH];

  // The tag FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    logic [TW-1:0] n;
    if (p == TAG_LAST) begin
      n = TW'(0);
    end else begin
      n = p + TW'(1);
    end
    return n;
  endfunction

  // Redirect targets are forced word aligned; the low bits are ignored.
  assign redirect_low_unused = ^i_redirect_pc[1:0];

  // Issue/accept decisions: a request needs a free credit both in flight and
  // in the FIFO, so every returning non-stale response always finds room.
  always_comb begin
    credit_sum       = SW'(count) + SW'(outstanding);
    head_valid       = (count != CW'(0));
    pop              = head_valid && i_ready;
    issue            = (state == RUN) && (outstanding < MAX_OUT_V) &&
                       (credit_sum < DEPTH_V) && !i_redirect;
    push             = i_imem_valid && !i_redirect && (discard == OW'(0));
    outstanding_next = outstanding + OW'(issue) - OW'(i_imem_valid);
  end

  // Run/idle state follows the fetch enable one edge later.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (d_i_ce) state <= RUN;
          else        state <= IDLE;
        end
        RUN: begin
          if (!d_i_ce) state <= IDLE;
          else         state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Program counter: redirect wins, otherwise advance one word per request.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      pc <= RESET_PC;
    end else if (i_redirect) begin
      pc <= {i_redirect_pc[PC_WIDTH-1:2], 2'b00};
    end else if (issue) begin
      pc <= pc + PC_WIDTH'(4);
    end else begin
      pc <= pc;
    end
  end

  // In-flight accounting; on redirect everything still in flight is stale,
  // except a response arriving this very cycle which is dropped right away.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      outstanding <= OW'(0);
      discard     <= OW'(0);
    end else begin
      outstanding <= outstanding_next;
      if (i_redirect) begin
        discard <= outstanding - OW'(i_imem_valid);
      end else if (i_imem_valid && (discard != OW'(0))) begin
        discard <= discard - OW'(1);
      end else begin
        discard <= discard;
      end
    end
  end

  // Address-tag FIFO pointers; stale tags are simply thrown away on redirect.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      tag_wr <= TW'(0);
      tag_rd <= TW'(0);
    end else if (i_redirect) begin
      tag_wr <= TW'(0);
      tag_rd <= TW'(0);
    end else begin
      if (issue) tag_wr <= tag_inc(tag_wr);
      if (push)  tag_rd <= tag_inc(tag_rd);
    end
  end

  // Address-tag storage written with the PC of each issued request.
  always_ff @(posedge d_clk) begin
    if (issue) tag_mem[tag_wr] <= pc;
  end

  // Instruction FIFO control; push and pop together leave count unchanged.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else if (i_redirect) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Instruction FIFO storage: each entry pairs a word with its fetch PC.
  always_ff @(posedge d_clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= tag_mem[tag_rd];
      fifo_instr[wr_ptr] <= i_imem_instr;
    end
  end

  assign o_imem_req  = issue;
  assign o_imem_addr = pc;
  assign o_valid     = head_valid;
  assign o_pc        = head_valid ? fifo_pc[rd_ptr]    : PC_WIDTH'(0);
  assign o_instr     = head_valid ? fifo_instr[rd_ptr] : IWIDTH'(0);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected {pc,instr}
// pairs; a monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps

module tb_fetch_queue;

  logic        d_clk;
  logic        d_rst;
  logic        d_i_ce;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid = 1'b0;
  logic [31:0] i_imem_instr = 32'h0;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        i_ready;

  // second instance, used only to watch its request addresses
  logic        ce2;
  logic        rdr2 = 1'b0;
  logic [31:0] rpc2 = 32'h0;
  logic        iv2  = 1'b0;
  logic [31:0] ii2  = 32'h0;
  logic        rdy2 = 1'b1;
  logic        req2;
  logic [31:0] addr2;
  logic        v2;
  logic [31:0] pc2;
  logic [31:0] ins2;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [31:0] a;
    int          due;
  } rq_t;
  rq_t mq[$];

  fetch_queue u_dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_ce(d_i_ce),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_valid(i_imem_valid), .i_imem_instr(i_imem_instr),
    .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr), .i_ready(i_ready)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_ce(ce2),
    .i_redirect(rdr2), .i_redirect_pc(rpc2),
    .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_valid(iv2), .i_imem_instr(ii2),
    .o_valid(v2), .o_pc(pc2), .o_instr(ins2), .i_ready(rdy2)
  );

  initial d_clk = 1'b0;
  always #5 d_clk = ~d_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // imem model: capture requests at the edge, answer after lat cycles
  always @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      mq.delete();
      cyc = 0;
    end else begin
      cyc = cyc + 1;
      if (o_imem_req) mq.push_back('{o_imem_addr, cyc + lat - 1});
    end
  end

  // imem model response driver
  always @(negedge d_clk) begin
    rq_t r;
    if (d_rst && mq.size() > 0 && mq[0].due == cyc) begin
      r = mq.pop_front();
      i_imem_valid = 1'b1;
      i_imem_instr = r.a | 32'hA000_0000;
    end else begin
      i_imem_valid = 1'b0;
      i_imem_instr = 32'h0;
    end
  end

  // scoreboard monitor: every accepted handshake must match the next expectation
  always @(negedge d_clk) begin
    logic [31:0] e;
    #1;
    if (d_rst && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual_pc=%h required=none", o_pc);
      end else begin
        e = exp_q.pop_front();
        if (o_pc !== e || o_instr !== (e | 32'hA000_0000)) begin
          errors++;
          $display("FAIL pop actual=%h/%h required=%h/%h", o_pc, o_instr, e, e | 32'hA000_0000);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge d_clk);
    #2;
    d_rst = 1'b0; d_i_ce = 1'b0; i_ready = 1'b0; i_redirect = 1'b0; ce2 = 1'b0;
    repeat (2) @(negedge d_clk);
    #2;
    d_rst = 1'b1;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    do begin
      @(negedge d_clk);
      n++;
    end while (exp_q.size() != 0 && n < lim);
    i_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int first_req, vi, gaps, bad, reqs, nv, nreq, extra, n2, found;
    logic [31:0] a2 [3];
    d_rst = 1'b0; d_i_ce = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_ready = 1'b0; ce2 = 1'b0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_req", o_imem_req, 0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_addr2", addr2, 32'hFFFF_FFF8);
    @(negedge d_clk);
    #2;
    d_rst = 1'b1;

    // 1: streaming at one instruction per cycle, latency 2
    lat = 1;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(k * 4));
    @(negedge d_clk);
    d_i_ce = 1'b1; i_ready = 1'b1;
    first_req = -1; vi = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_imem_req && first_req < 0) first_req = i;
      if (o_valid) begin vi = i; break; end
      @(negedge d_clk);
    end
    chk("t1_latency", 32'(vi - first_req), 2);
    gaps = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge d_clk); #1;
      if (!o_valid) gaps++;
    end
    chk("t1_gaps", gaps, 0);
    wait_drain(20);

    // 2: backpressure fills exactly DEPTH entries, then drains in order
    do_reset();
    @(negedge d_clk);
    d_i_ce = 1'b1;
    repeat (12) @(negedge d_clk);
    #1;
    chk("t2_valid", o_valid, 1);
    chk("t2_head", o_pc, 32'h0);
    bad = 0; reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge d_clk); #1;
      if (o_pc !== 32'h0 || o_instr !== 32'hA000_0000) bad++;
      if (o_imem_req) reqs++;
    end
    chk("t2_head_stable", bad, 0);
    chk("t2_stall_noreq", reqs, 0);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
    @(negedge d_clk);
    i_ready = 1'b1;
    #1;
    chk("t2_full_noreq", o_imem_req, 0);
    nv = o_valid ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge d_clk); #1;
      if (o_valid) nv++;
    end
    chk("t2_nogap", nv, 5);
    wait_drain(20);

    // 3: redirect with 3 requests in flight on a 3-cycle imem
    do_reset();
    lat = 3;
    @(negedge d_clk);
    d_i_ce = 1'b1; i_ready = 1'b1;
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_imem_req) nreq++;
      if (nreq == 3) break;
      @(negedge d_clk);
    end
    chk("t3_three_req", nreq, 3);
    @(negedge d_clk);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0103;
    #1;
    chk("t3_rdr_noreq", o_imem_req, 0);
    chk("t3_stale_rsp", i_imem_valid, 1);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    exp_q.push_back(32'h108); exp_q.push_back(32'h10C);
    @(negedge d_clk);
    i_redirect = 1'b0;
    #1;
    chk("t3_req", o_imem_req, 1);
    chk("t3_addr", o_imem_addr, 32'h100);
    wait_drain(80);

    // 4: redirect coinciding with a pop and a returning response
    do_reset();
    lat = 1;
    exp_q.push_back(32'h0);   exp_q.push_back(32'h200);
    exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    @(negedge d_clk);
    d_i_ce = 1'b1; i_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_imem_req) break;
      @(negedge d_clk);
    end
    @(negedge d_clk);
    @(negedge d_clk);
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    #1;
    chk("t4_pop_in_rdr", o_valid, 1);
    chk("t4_rsp_in_rdr", i_imem_valid, 1);
    @(negedge d_clk);
    i_redirect = 1'b0;
    #1;
    chk("t4_empty_after", o_valid, 0);
    chk("t4_new_addr", o_imem_addr, 32'h200);
    wait_drain(30);

    // 5: PC wraps through the top of the address space
    do_reset();
    @(negedge d_clk);
    ce2 = 1'b1;
    n2 = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req2 && n2 < 3) begin
        a2[n2] = addr2;
        n2++;
      end
      @(negedge d_clk);
    end
    ce2 = 1'b0;
    chk("t5_nreq", n2, 3);
    chk("t5_addr0", a2[0], 32'hFFFF_FFF8);
    chk("t5_addr1", a2[1], 32'hFFFF_FFFC);
    chk("t5_addr2", a2[2], 32'h0000_0000);

    // 6: fetch disable with 2 in flight, then asynchronous reset mid-stream
    do_reset();
    lat = 3;
    i_ready = 1'b1;
    @(negedge d_clk);
    d_i_ce = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_imem_req) break;
      @(negedge d_clk);
    end
    @(negedge d_clk);
    d_i_ce = 1'b0;
    #1;
    chk("t6_second_req", o_imem_req, 1);
    chk("t6_second_addr", o_imem_addr, 32'h4);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge d_clk); #1;
      if (o_imem_req) extra++;
    end
    chk("t6_idle_noreq", extra, 0);
    wait_drain(10);

    lat = 1;
    @(negedge d_clk);
    d_i_ce = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_valid && o_imem_req) begin found = 1; break; end
      @(negedge d_clk);
    end
    chk("t6_busy_before_rst", found, 1);
    #2;
    d_rst = 1'b0;
    #1;
    chk("t6_async_valid", o_valid, 0);
    chk("t6_async_req", o_imem_req, 0);
    chk("t6_async_pc", o_pc, 32'h0);
    chk("t6_async_addr", o_imem_addr, 32'h0);
    d_i_ce = 1'b0;
    repeat (2) @(negedge d_clk);
    #2;
    d_rst = 1'b1;
    @(negedge d_clk); #1;
    chk("t6_post_rst_valid", o_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
